// File: rtl/decode_forward_unit.sv
// Decode-side operand forwarding, load-use hazard detection and the ID/EXE
// pipeline register, with a saturating count of stall cycles.
module decode_forward_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic [DATA_W-1:0] qa,
    input  logic [DATA_W-1:0] qb,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic              id_wmem,
    input  logic              id_aluimm,
    input  logic [3:0]        id_aluc,
    input  logic [ADDR_W-1:0] id_dest,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              e_wreg,
    input  logic              e_m2reg,
    input  logic [ADDR_W-1:0] e_dest,
    input  logic [DATA_W-1:0] e_alu,
    input  logic              m_wreg,
    input  logic              m_m2reg,
    input  logic [ADDR_W-1:0] m_dest,
    input  logic [DATA_W-1:0] m_alu,
    input  logic [DATA_W-1:0] m_mo,
    input  logic              flush,
    output logic              stall,
    output logic              ex_wreg,
    output logic              ex_m2reg,
    output logic              ex_wmem,
    output logic              ex_aluimm,
    output logic [3:0]        ex_aluc,
    output logic [ADDR_W-1:0] ex_dest,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic              bubble;

    // Operand A: EXE result beats MEM result; a load still in EXE has no data
    // yet, and r0 is never forwarded. WB needs no path since the register
    // file writes on the negedge before this stage samples.
    always_comb begin
        fwd_a = qa;
        if (rs == REG_ZERO) begin
            fwd_a = qa;
        end else if (e_wreg && !e_m2reg && (e_dest == rs)) begin
            fwd_a = e_alu;
        end else if (m_wreg && (m_dest == rs)) begin
            fwd_a = m_m2reg ? m_mo : m_alu;
        end
    end

    // Operand B: same selection as operand A, using rt/qb.
    always_comb begin
        fwd_b = qb;
        if (rt == REG_ZERO) begin
            fwd_b = qb;
        end else if (e_wreg && !e_m2reg && (e_dest == rt)) begin
            fwd_b = e_alu;
        end else if (m_wreg && (m_dest == rt)) begin
            fwd_b = m_m2reg ? m_mo : m_alu;
        end
    end

    // Load-use hazard: a load in EXE targeting a register this instruction
    // actually reads. One bubble lets the load reach MEM, where m_mo forwards.
    always_comb begin
        stall = e_wreg && e_m2reg && (e_dest != REG_ZERO) &&
                ((use_rs && (e_dest == rs)) || (use_rt && (e_dest == rt)));
        bubble = stall || flush;
    end

    // ID/EXE register: a bubble on stall or flush, otherwise the decoded
    // instruction with its forwarded operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_wreg   <= 1'b0;
            ex_m2reg  <= 1'b0;
            ex_wmem   <= 1'b0;
            ex_aluimm <= 1'b0;
            ex_aluc   <= 4'h0;
            ex_dest   <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm    <= '0;
        end else if (bubble) begin
            ex_wreg   <= 1'b0;
            ex_m2reg  <= 1'b0;
            ex_wmem   <= 1'b0;
            ex_aluimm <= 1'b0;
            ex_aluc   <= 4'h0;
            ex_dest   <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
            ex_imm    <= '0;
        end else begin
            ex_wreg   <= id_wreg;
            ex_m2reg  <= id_m2reg;
            ex_wmem   <= id_wmem;
            ex_aluimm <= id_aluimm;
            ex_aluc   <= id_aluc;
            ex_dest   <= id_dest;
            ex_a      <= fwd_a;
            ex_b      <= fwd_b;
            ex_imm    <= id_imm;
        end
    end

    // Stall-cycle counter, held at all-ones once full rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_forward_unit.sv
// Self-checking bench for decode_forward_unit: directed vector table,
// hand-written reset/saturation sequences and randomized traffic against a
// rule-level reference model.
module tb_decode_forward_unit;

    typedef struct {
        logic [4:0]  rs, rt;
        logic        use_rs, use_rt;
        logic [31:0] qa, qb;
        logic        id_wreg, id_m2reg, id_wmem, id_aluimm;
        logic [3:0]  id_aluc;
        logic [4:0]  id_dest;
        logic [31:0] id_imm;
        logic        e_wreg, e_m2reg;
        logic [4:0]  e_dest;
        logic [31:0] e_alu;
        logic        m_wreg, m_m2reg;
        logic [4:0]  m_dest;
        logic [31:0] m_alu, m_mo;
        logic        flush;
    } in_t;

    typedef struct {
        in_t         in;
        logic        exp_stall;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]  rs, rt, id_dest, e_dest, m_dest;
    logic        use_rs, use_rt, id_wreg, id_m2reg, id_wmem, id_aluimm;
    logic [3:0]  id_aluc;
    logic [31:0] qa, qb, id_imm, e_alu, m_alu, m_mo;
    logic        e_wreg, e_m2reg, m_wreg, m_m2reg, flush;
    logic        stall, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm;
    logic [3:0]  ex_aluc;
    logic [4:0]  ex_dest;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [15:0] stall_cnt;

    decode_forward_unit #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .qa(qa), .qb(qb), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
        .id_aluimm(id_aluimm), .id_aluc(id_aluc), .id_dest(id_dest), .id_imm(id_imm),
        .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_dest(e_dest), .e_alu(e_alu),
        .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_dest(m_dest), .m_alu(m_alu), .m_mo(m_mo),
        .flush(flush), .stall(stall), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
        .ex_wmem(ex_wmem), .ex_aluimm(ex_aluimm), .ex_aluc(ex_aluc), .ex_dest(ex_dest),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .stall_cnt(stall_cnt)
    );

    int          tests  = 0;
    int          failed = 0;
    logic [15:0] cnt_model = 16'h0;
    logic [31:0] exp_q[$];
    vec_t        vecs[11];

    // scoreboard compare
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic in_t mk(input logic [4:0] r_s, input logic [4:0] r_t,
                               input logic u_s, input logic u_t,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic ew, input logic em, input logic [4:0] ed,
                               input logic [31:0] ea,
                               input logic mw, input logic mm, input logic [4:0] md,
                               input logic [31:0] ma, input logic [31:0] mo,
                               input logic fl);
        in_t v;
        v.rs = r_s; v.rt = r_t; v.use_rs = u_s; v.use_rt = u_t; v.qa = a; v.qb = b;
        v.id_wreg = 1'b1; v.id_m2reg = 1'b1; v.id_wmem = 1'b1; v.id_aluimm = 1'b1;
        v.id_aluc = 4'h9; v.id_dest = 5'h1A; v.id_imm = 32'hCAFE0001;
        v.e_wreg = ew; v.e_m2reg = em; v.e_dest = ed; v.e_alu = ea;
        v.m_wreg = mw; v.m_m2reg = mm; v.m_dest = md; v.m_alu = ma; v.m_mo = mo;
        v.flush = fl;
        return v;
    endfunction

    // driver
    task automatic drive(input in_t v);
        rs = v.rs; rt = v.rt; use_rs = v.use_rs; use_rt = v.use_rt; qa = v.qa; qb = v.qb;
        id_wreg = v.id_wreg; id_m2reg = v.id_m2reg; id_wmem = v.id_wmem;
        id_aluimm = v.id_aluimm; id_aluc = v.id_aluc; id_dest = v.id_dest; id_imm = v.id_imm;
        e_wreg = v.e_wreg; e_m2reg = v.e_m2reg; e_dest = v.e_dest; e_alu = v.e_alu;
        m_wreg = v.m_wreg; m_m2reg = v.m_m2reg; m_dest = v.m_dest; m_alu = v.m_alu;
        m_mo = v.m_mo; flush = v.flush;
    endtask

    // Reference: the newest in-flight producer whose value already exists
    // supplies the operand; r0 and everything else read the register file.
    function automatic logic [31:0] model_src(input logic [4:0] idx, input logic [31:0] rf,
                                              input in_t v);
        logic        hit[2];
        logic [31:0] val[2];
        hit[0] = v.e_wreg && !v.e_m2reg && (v.e_dest == idx);
        val[0] = v.e_alu;
        hit[1] = v.m_wreg && (v.m_dest == idx);
        val[1] = v.m_m2reg ? v.m_mo : v.m_alu;
        if (idx == 5'd0) return rf;
        for (int i = 0; i < 2; i++) if (hit[i]) return val[i];
        return rf;
    endfunction

    function automatic logic model_stall(input in_t v);
        logic needs_load;
        needs_load = (v.use_rs && v.rs == v.e_dest) || (v.use_rt && v.rt == v.e_dest);
        return v.e_wreg && v.e_m2reg && (v.e_dest != 5'd0) && needs_load;
    endfunction

    // One ID cycle: check stall before the edge, then the registered result.
    task automatic run_cycle(input string tag, input in_t v, input logic exp_stall,
                             input logic [31:0] exp_a, input logic [31:0] exp_b);
        logic bub;
        @(negedge clk);
        drive(v);
        #1;
        check({tag, ".stall"}, {63'd0, stall}, {63'd0, exp_stall});
        bub = exp_stall || v.flush;
        exp_q.push_back(bub ? 32'd0 : exp_a);
        exp_q.push_back(bub ? 32'd0 : exp_b);
        @(posedge clk);
        #1;
        if (exp_stall && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
        check({tag, ".ex_a"}, {32'd0, ex_a}, {32'd0, exp_q.pop_front()});
        check({tag, ".ex_b"}, {32'd0, ex_b}, {32'd0, exp_q.pop_front()});
        check({tag, ".ex_ctrl"}, {56'd0, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_aluc},
              bub ? 64'd0 : {56'd0, v.id_wreg, v.id_m2reg, v.id_wmem, v.id_aluimm, v.id_aluc});
        check({tag, ".ex_dest"}, {59'd0, ex_dest}, bub ? 64'd0 : {59'd0, v.id_dest});
        check({tag, ".ex_imm"}, {32'd0, ex_imm}, bub ? 64'd0 : {32'd0, v.id_imm});
        check({tag, ".stall_cnt"}, {48'd0, stall_cnt}, {48'd0, cnt_model});
    endtask

    initial begin
        in_t v;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // reset state
        #12;
        check("reset.ex_a", {32'd0, ex_a}, 64'd0);
        check("reset.ex_ctrl", {55'd0, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_aluc, ex_dest[4]}, 64'd0);
        check("reset.stall_cnt", {48'd0, stall_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed vector table
        vecs[0]  = '{mk(3, 0, 1, 0, 32'h20000022, 32'h11, 1, 0, 3, 32'h12345678, 0, 0, 0, 0, 0, 0),
                     1'b0, 32'h12345678, 32'h11};
        vecs[1]  = '{mk(1, 5, 1, 1, 32'hA1, 32'hB5, 1, 0, 5, 32'hAAAA0000, 1, 0, 5, 32'hBBBB0000, 0, 0),
                     1'b0, 32'hA1, 32'hAAAA0000};
        vecs[2]  = '{mk(7, 2, 1, 1, 32'h70, 32'h22, 1, 1, 7, 32'hDEAD, 0, 0, 0, 0, 0, 0),
                     1'b1, 32'h0, 32'h0};
        vecs[3]  = '{mk(7, 2, 1, 1, 32'h70, 32'h22, 0, 0, 0, 0, 1, 1, 7, 32'h5555, 32'h60000066, 0),
                     1'b0, 32'h60000066, 32'h22};
        vecs[4]  = '{mk(0, 1, 1, 1, 32'h0, 32'h10, 1, 0, 0, 32'hFFFF0000, 1, 0, 0, 32'hEEEE, 0, 0),
                     1'b0, 32'h0, 32'h10};
        vecs[5]  = '{mk(0, 4, 1, 1, 32'h0, 32'h44, 1, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0),
                     1'b0, 32'h0, 32'h44};
        vecs[6]  = '{mk(1, 6, 1, 0, 32'h11, 32'h66, 1, 1, 6, 32'h99, 0, 0, 0, 0, 0, 0),
                     1'b0, 32'h11, 32'h66};
        vecs[7]  = '{mk(7, 0, 1, 0, 32'h70, 32'h0, 1, 1, 7, 32'h77, 0, 0, 0, 0, 0, 1),
                     1'b1, 32'h0, 32'h0};
        vecs[8]  = '{mk(2, 0, 1, 0, 32'h22, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),
                     1'b0, 32'h22, 32'h0};
        vecs[9]  = '{mk(9, 9, 1, 1, 32'h90, 32'h91, 0, 0, 0, 0, 1, 0, 9, 32'h13579BDF, 32'h0, 0),
                     1'b0, 32'h13579BDF, 32'h13579BDF};
        vecs[10] = '{mk(1, 8, 1, 1, 32'h10, 32'h80, 1, 1, 8, 32'h88, 0, 0, 0, 0, 0, 0),
                     1'b1, 32'h0, 32'h0};
        for (int i = 0; i < 11; i++)
            run_cycle($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp_stall,
                      vecs[i].exp_a, vecs[i].exp_b);

        // async reset mid-cycle with ex_* loaded and the counter nonzero
        run_cycle("pre_rst", vecs[9].in, 1'b0, 32'h13579BDF, 32'h13579BDF);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async.ex_a", {32'd0, ex_a}, 64'd0);
        check("rst_async.ex_b", {32'd0, ex_b}, 64'd0);
        check("rst_async.ex_ctrl", {55'd0, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_aluc, ex_dest[0]}, 64'd0);
        check("rst_async.ex_dest_imm", {27'd0, ex_dest, ex_imm}, 64'd0);
        check("rst_async.stall_cnt", {48'd0, stall_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_model = 16'h0;

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            v = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom(), $urandom(),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3), $urandom(),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3), $urandom(),
                   $urandom(), ($urandom_range(0, 9) == 0));
            v.id_wreg = $urandom_range(0, 1); v.id_m2reg = $urandom_range(0, 1);
            v.id_wmem = $urandom_range(0, 1); v.id_aluimm = $urandom_range(0, 1);
            v.id_aluc = $urandom_range(0, 15); v.id_dest = $urandom_range(0, 31);
            v.id_imm = $urandom();
            run_cycle("rand", v, model_stall(v), model_src(v.rs, v.qa, v), model_src(v.rt, v.qb, v));
        end

        // saturation: hold a load-use hazard far beyond the counter range
        @(negedge clk);
        drive(vecs[2].in);
        repeat (65540) @(posedge clk);
        #1;
        check("sat.stall", {63'd0, stall}, 64'd1);
        check("sat.stall_cnt", {48'd0, stall_cnt}, 64'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hold.stall_cnt", {48'd0, stall_cnt}, 64'hFFFF);
        check("sat_hold.ex_wreg", {63'd0, ex_wreg}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
